imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a program as a byte stream over a valid/ready handshake and assembles 16-bit instruction words, MSB first.
- Issues one write per word into the instruction memory's write port, at byte address 0, 2, 4, … (the memory indexes words by Address >> 1).
- Stops after writing the halt word 16'hFFFF, or raises an error if the memory fills before the halt word arrives.

Parameters:
- DEPTH, 1024, instruction memory capacity in 16-bit words.
- HALT_WORD, 16'hFFFF, terminator word; it is written to memory, then loading ends.

Ports:
- Clock  input  1  single clock; all state updates on its rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  begin a load session; honoured only in IDLE, DONE or ERROR
- ByteValid  input  1  ByteData holds a valid program byte
- ByteData  input  8  program byte; high byte of each word first
- ByteReady  output  1  loader can accept a byte this cycle
- WriteEnable  output  1  single-cycle write strobe to the instruction memory
- WriteAddress  output  16  byte address of the word being written; always even
- WriteData  output  16  assembled instruction word
- Busy  output  1  a load session is in progress
- Done  output  1  halt word written; held until the next Start or Reset
- Overflow  output  1  memory filled without a halt word; held until the next Start or Reset
- WordCount  output  16  words written in the current session

Behaviour:
- Reset values: every output is 0, FSM in IDLE, internal byte latch cleared.
- Reset has priority over all other inputs in any state. Reset mid-word discards the partial word and issues no write.
- A byte transfer occurs on a cycle with ByteValid=1 and ByteReady=1. ByteValid with ByteReady=0 has no effect.
- ByteReady is a registered state decode (1 exactly in HI and LO). It does not depend combinationally on ByteValid.
- FSM states: IDLE, HI, LO, WRITE, DONE, ERROR.
- IDLE:
  - All flags are 0.
  - On Start: WordCount←0, Done←0, Overflow←0, go to HI.
- HI:
  - Busy=1, ByteReady=1.
  - On transfer: high byte←ByteData, go to LO.
  - Otherwise stay in HI.
- LO:
  - Busy=1, ByteReady=1.
  - On transfer: WriteData←{high byte, ByteData}, WriteAddress←WordCount<<1, go to WRITE.
- WRITE:
  - Busy=1, ByteReady=0, WriteEnable=1 for exactly this one cycle. WriteAddress and WriteData are stable for the whole cycle.
  - WordCount←WordCount+1 on exit.
  - Exit priority:
    - If WriteData==HALT_WORD: go to DONE.
    - Else if WordCount+1==DEPTH: go to ERROR.
    - Else: go to HI.
  - The halt check takes precedence, so a halt word in the last slot ends in DONE, not ERROR.
- DONE:
  - Busy=0, Done=1, ByteReady=0.
  - On Start: clear the flags and WordCount, go to HI.
- ERROR:
  - Busy=0, Overflow=1, ByteReady=0.
  - Further bytes are refused.
  - On Start: same restart as DONE.
- Start asserted in HI, LO or WRITE is ignored.
- WriteAddress and WriteData hold their last value outside WRITE. Only WriteEnable qualifies them.
- Latency and throughput:
  - The write strobe is asserted in the cycle after the low-byte transfer.
  - Peak rate is one word per 3 cycles: byte, byte, write.
  - Idle cycles on ByteValid stretch HI and LO with no side effects.
- Width rules:
  - WriteAddress = WordCount[14:0] concatenated with 1'b0.
  - DEPTH ≤ 32768, so the address never wraps.
  - WordCount never exceeds DEPTH.

Test Plan:
- Ten-word program, back-to-back bytes 71 0F 72 07 26 C0 17 80 3B 80 0B C0 4B 40 6E 40 6B 40 FF FF after Start:
  - 10 writes at addresses 0, 2, …, 18.
  - Write at address 4 carries 16'h26C0; last write carries 16'hFFFF.
  - Then Done=1, Busy=0, WordCount=10.
- Same stream with random 0–3 cycle ByteValid gaps: identical write sequence, no extra WriteEnable pulses, ByteReady never high in the WRITE cycle.
- DEPTH=4, stream of 4 words 0x1234 and no halt:
  - Writes at addresses 0, 2, 4, 6, then Overflow=1, ByteReady=0.
  - A fifth byte offered with ByteValid is never accepted.
- Reset asserted one cycle after the high byte 0xAB is accepted:
  - All outputs read 0 on the next cycle and no write occurs.
  - New Start plus bytes 12 34 FF FF writes 16'h1234 at address 0 and 16'hFFFF at address 2.
- Start pulsed while in LO: ignored, the word completes normally. Start in DONE: WordCount←0, Done←0, next word lands at address 0.
- Halt as the first word (FF FF): single write of 16'hFFFF at address 0, Done=1, WordCount=1. With DEPTH=1 the result is the same (Overflow stays 0).

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles MSB-first byte pairs into 16-bit words
// and writes them to consecutive even byte addresses until the halt word is written.
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        WriteEnable,
  output logic [15:0] WriteAddress,
  output logic [15:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Overflow,
  output logic [15:0] WordCount
);

  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [7:0]  hi_byte, hi_byte_next;
  logic [15:0] data_next, addr_next, count_next;
  logic        xfer;

  // Next-state and datapath update selection
  always_comb begin
    state_next   = state;
    hi_byte_next = hi_byte;
    data_next    = WriteData;
    addr_next    = WriteAddress;
    count_next   = WordCount;
    xfer         = ByteValid & ByteReady;
    case (state)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          count_next = '0;
          state_next = HI;
        end
      end
      HI: begin
        if (xfer) begin
          hi_byte_next = ByteData;
          state_next   = LO;
        end
      end
      LO: begin
        if (xfer) begin
          data_next  = {hi_byte, ByteData};
          addr_next  = {WordCount[14:0], 1'b0};
          state_next = WRITE;
        end
      end
      WRITE: begin
        count_next = WordCount + 16'd1;
        // Halt wins over a full memory so a halt in the last slot still ends cleanly
        if (WriteData == HALT_WORD) begin
          state_next = DONE;
        end else if (CNT_W'(WordCount) + CNT_W'(1) == DEPTH_W) begin
          state_next = ERROR;
        end else begin
          state_next = HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with flags decoded from the next state so they are registered
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      hi_byte      <= '0;
      WriteData    <= '0;
      WriteAddress <= '0;
      WordCount    <= '0;
      ByteReady    <= 1'b0;
      WriteEnable  <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      hi_byte      <= hi_byte_next;
      WriteData    <= data_next;
      WriteAddress <= addr_next;
      WordCount    <= count_next;
      ByteReady    <= (state_next == HI) || (state_next == LO);
      WriteEnable  <= (state_next == WRITE);
      Busy         <= (state_next == HI) || (state_next == LO) || (state_next == WRITE);
      Done         <= (state_next == DONE);
      Overflow     <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: three instances (DEPTH 1024, 4, 1) share one driven
// stimulus port, selected by sel; a scoreboard queue checks every write strobe.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst, start, valid;
  logic [7:0] data;
  int         sel;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  logic        rdy [3], we [3], busy [3], done [3], ovf [3];
  logic [15:0] wa [3], wd [3], wc [3];
  logic        st [3], bv [3];

  for (genvar g = 0; g < 3; g++) begin : g_in
    assign st[g] = start && (sel == g);
    assign bv[g] = valid && (sel == g);
  end

  imem_loader #(.DEPTH(1024)) dut0 (
    .Clock(clk), .Reset(rst), .Start(st[0]), .ByteValid(bv[0]), .ByteData(data),
    .ByteReady(rdy[0]), .WriteEnable(we[0]), .WriteAddress(wa[0]), .WriteData(wd[0]),
    .Busy(busy[0]), .Done(done[0]), .Overflow(ovf[0]), .WordCount(wc[0]));
  imem_loader #(.DEPTH(4)) dut1 (
    .Clock(clk), .Reset(rst), .Start(st[1]), .ByteValid(bv[1]), .ByteData(data),
    .ByteReady(rdy[1]), .WriteEnable(we[1]), .WriteAddress(wa[1]), .WriteData(wd[1]),
    .Busy(busy[1]), .Done(done[1]), .Overflow(ovf[1]), .WordCount(wc[1]));
  imem_loader #(.DEPTH(1)) dut2 (
    .Clock(clk), .Reset(rst), .Start(st[2]), .ByteValid(bv[2]), .ByteData(data),
    .ByteReady(rdy[2]), .WriteEnable(we[2]), .WriteAddress(wa[2]), .WriteData(wd[2]),
    .Busy(busy[2]), .Done(done[2]), .Overflow(ovf[2]), .WordCount(wc[2]));

  logic        m_rdy, m_we, m_busy, m_done, m_ovf;
  logic [15:0] m_wa, m_wd, m_wc;
  always_comb begin
    m_rdy = rdy[sel]; m_we = we[sel]; m_busy = busy[sel]; m_done = done[sel];
    m_ovf = ovf[sel]; m_wa = wa[sel]; m_wd = wd[sel]; m_wc = wc[sel];
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (m_we) begin
      check("ready_in_write", 64'(m_rdy), 64'(0));
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", m_wa, m_wd);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("write", 64'({m_wa, m_wd}), 64'({e.addr, e.data}));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    valid = 1'b1;
    data  = b;
    n = 0;
    while (!m_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_rdy) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got ready 0 expected 1 for byte %0h", b);
      valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] addr, input int maxgap);
    q.push_back('{addr: addr, data: w});
    send_byte(w[15:8], $urandom_range(0, maxgap));
    send_byte(w[7:0], $urandom_range(0, maxgap));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!m_done && !m_ovf && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(m_done || m_ovf)) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: got done 0 ovf 0 expected a terminal flag");
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] addr;
  } vec_t;
  vec_t prog [10];

  initial begin
    prog[0] = '{16'h710F, 16'd0};  prog[1] = '{16'h7207, 16'd2};
    prog[2] = '{16'h26C0, 16'd4};  prog[3] = '{16'h1780, 16'd6};
    prog[4] = '{16'h3B80, 16'd8};  prog[5] = '{16'h0BC0, 16'd10};
    prog[6] = '{16'h4B40, 16'd12}; prog[7] = '{16'h6E40, 16'd14};
    prog[8] = '{16'h6B40, 16'd16}; prog[9] = '{16'hFFFF, 16'd18};

    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; sel = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({m_rdy, m_we, m_busy, m_done, m_ovf, m_wa, m_wd, m_wc}), 64'(0));
    rst = 1'b0;

    // Ten-word program, back-to-back bytes, then with random gaps
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      check("start_busy", 64'({m_busy, m_rdy, m_done, m_wc}), 64'({1'b1, 1'b1, 1'b0, 16'd0}));
      for (int i = 0; i < 10; i++) send_word(prog[i].word, prog[i].addr, pass * 3);
      wait_end();
      check("prog_flags", 64'({m_done, m_busy, m_ovf, m_rdy}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
      check("prog_count", 64'(m_wc), 64'(10));
      check("prog_queue", 64'(q.size()), 64'(0));
    end

    // Overflow with DEPTH=4 and no halt word
    sel = 1;
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(16'h1234, 16'(i * 2), 0);
    wait_end();
    check("ovf_flags", 64'({m_ovf, m_done, m_busy, m_rdy}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    check("ovf_count", 64'(m_wc), 64'(4));
    valid = 1'b1;
    data = 8'h56;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ovf_refuse", 64'({m_rdy, m_wc}), 64'({1'b0, 16'd4}));
    end
    valid = 1'b0;
    check("ovf_queue", 64'(q.size()), 64'(0));

    // Reset mid-word discards the partial word
    sel = 0;
    pulse_start();
    send_byte(8'hAB, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midword_reset", 64'({m_rdy, m_we, m_busy, m_done, m_ovf, m_wa, m_wd, m_wc}), 64'(0));
    rst = 1'b0;
    pulse_start();
    send_word(16'h1234, 16'd0, 0);
    send_word(16'hFFFF, 16'd2, 0);
    wait_end();
    check("after_reset", 64'({m_done, m_wc}), 64'({1'b1, 16'd2}));

    // Start in LO is ignored; Start in DONE restarts at address 0
    pulse_start();
    q.push_back('{addr: 16'd0, data: 16'hBEEF});
    send_byte(8'hBE, 0);
    pulse_start();
    check("start_in_lo", 64'({m_busy, m_rdy, m_wc}), 64'({1'b1, 1'b1, 16'd0}));
    send_byte(8'hEF, 0);
    send_word(16'hFFFF, 16'd2, 0);
    wait_end();
    check("lo_done", 64'({m_done, m_wc}), 64'({1'b1, 16'd2}));
    pulse_start();
    check("start_in_done", 64'({m_done, m_busy, m_wc}), 64'({1'b0, 1'b1, 16'd0}));
    send_word(16'hFFFF, 16'd0, 0);
    wait_end();
    check("halt_first", 64'({m_done, m_ovf, m_wc}), 64'({1'b1, 1'b0, 16'd1}));

    // Halt in the only slot of a DEPTH=1 memory
    sel = 2;
    pulse_start();
    send_word(16'hFFFF, 16'd0, 0);
    wait_end();
    check("depth1_halt", 64'({m_done, m_ovf, m_busy, m_wc}), 64'({1'b1, 1'b0, 1'b0, 16'd1}));
    check("final_queue", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
